// File: rtl/store_buffer.sv
// In-order store buffer: queues sb/sh/sw stores as lane-aligned word writes and drains them at the head.
// Define STORE_BUFFER_MERGE_EN to let a new store merge into the newest (non-head) entry for the same word.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [1:0]              StoreSignal,
    input  logic [31:0]             Addr,
    input  logic [31:0]             In,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    output logic [31:0]             MemAddr,
    output logic [31:0]             MemData,
    output logic [3:0]              MemByteEn,
    output logic                    MemValid,
    input  logic                    MemReady,
    output logic                    Misalign,
    output logic [$clog2(DEPTH):0]  Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Request side accepts on ReqValid & ReqReady; memory side pops on MemValid & MemReady.
    // ReqReady comes only from registered state, so a same-cycle pop never frees a full buffer.

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          misalign_q;

    logic          legal;
    logic [31:0]   req_data;
    logic [3:0]    req_be;
    logic [31:0]   word_addr;
    logic          fire;
    logic          accept;
    logic          alloc;
    logic          pop;
    logic          not_empty;

    always_comb begin
        legal    = 1'b0;
        req_data = '0;
        req_be   = '0;
        case (StoreSignal)
            2'b01: begin
                legal    = (Addr[1:0] == 2'b00);
                req_data = In;
                req_be   = 4'b1111;
            end
            2'b10: begin
                legal    = 1'b1;
                req_data = {4{In[7:0]}};
                req_be   = 4'b0001 << Addr[1:0];
            end
            2'b11: begin
                legal    = ~Addr[0];
                req_data = {2{In[15:0]}};
                req_be   = Addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign word_addr = {Addr[31:2], 2'b00};
    assign not_empty = (count_q != '0);
    assign ReqReady  = (count_q != FULL);
    assign fire      = ReqValid & ReqReady & (StoreSignal != 2'b00);
    assign accept    = fire & legal;
    assign pop       = not_empty & MemReady;

`ifdef STORE_BUFFER_MERGE_EN
    logic [AW-1:0] newest;
    logic          merge;
    logic [31:0]   merged_data;

    // Requiring two entries keeps the head (possibly being presented) untouched.
    assign newest = wr_ptr - 1'b1;
    assign merge  = accept && (count_q >= CW'(2)) && (addr_mem[newest] == word_addr);
    assign alloc  = accept & ~merge;

    always_comb begin
        merged_data = data_mem[newest];
        for (int i = 0; i < 4; i++) begin
            if (req_be[i]) begin
                merged_data[8*i +: 8] = req_data[8*i +: 8];
            end
        end
    end
`else
    assign alloc = accept;
`endif

    // Entry storage carries no reset; outputs are masked while empty.
    always_ff @(posedge Clk) begin
        if (alloc) begin
            addr_mem[wr_ptr] <= word_addr;
            data_mem[wr_ptr] <= req_data;
            be_mem[wr_ptr]   <= req_be;
        end
`ifdef STORE_BUFFER_MERGE_EN
        else if (merge) begin
            data_mem[newest] <= merged_data;
            be_mem[newest]   <= be_mem[newest] | req_be;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= fire & ~legal;
            if (alloc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({alloc, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign MemValid  = not_empty;
    assign MemAddr   = not_empty ? addr_mem[rd_ptr] : '0;
    assign MemData   = not_empty ? data_mem[rd_ptr] : '0;
    assign MemByteEn = not_empty ? be_mem[rd_ptr]   : '0;
    assign Misalign  = misalign_q;
    assign Count     = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
// Build with +define+STORE_BUFFER_MERGE_EN to exercise write merging.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [1:0]    StoreSignal;
  logic [31:0]   Addr;
  logic [31:0]   In;
  logic          ReqValid;
  logic          ReqReady;
  logic [31:0]   MemAddr;
  logic [31:0]   MemData;
  logic [3:0]    MemByteEn;
  logic          MemValid;
  logic          MemReady;
  logic          Misalign;
  logic [CW-1:0] Count;

  int checks   = 0;
  int failures = 0;

  // entry layout: [67:36] word address, [35:4] data, [3:0] byte enables
  logic [67:0] exp_q[$];
  logic        exp_misalign;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StoreSignal(StoreSignal), .Addr(Addr), .In(In),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .MemAddr(MemAddr), .MemData(MemData),
    .MemByteEn(MemByteEn), .MemValid(MemValid), .MemReady(MemReady),
    .Misalign(Misalign), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                                 output logic legal, output logic [31:0] data, output logic [3:0] be);
    legal = 1'b0; data = '0; be = '0;
    if (s == 2'b01) begin
      legal = (a % 4 == 0); data = d; be = 4'hf;
    end else if (s == 2'b10) begin
      legal = 1'b1; data = {4{d[7:0]}}; be = 4'(1 << (a % 4));
    end else if (s == 2'b11) begin
      legal = (a % 2 == 0); data = {2{d[15:0]}}; be = ((a % 4) >= 2) ? 4'hc : 4'h3;
    end
  endfunction

  // Applies one rising edge worth of behaviour to the model from the currently driven inputs.
  function automatic void model_step();
    logic        legal;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] wa;
    int          n;
    bit          ready, pop, tried, acc, mrg;
    n     = exp_q.size();
    ready = (n != DEPTH);
    pop   = (n != 0) && MemReady;
    decode(StoreSignal, Addr, In, legal, d, be);
    wa    = (Addr / 4) * 4;
    tried = ReqValid && ready && (StoreSignal != 2'b00);
    acc   = tried && legal;
    exp_misalign = tried && !legal;
    mrg   = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
    if (acc && n >= 2 && exp_q[n-1][67:36] == wa) begin
      logic [67:0] e;
      e = exp_q[n-1];
      for (int i = 0; i < 4; i++) if (be[i]) e[4 + 8*i +: 8] = d[8*i +: 8];
      e[3:0] = e[3:0] | be;
      exp_q[n-1] = e;
      mrg = 1'b1;
    end
`endif
    if (pop) void'(exp_q.pop_front());
    if (acc && !mrg) exp_q.push_back({wa, d, be});
  endfunction

  task automatic check_outputs(input string tag);
    int          n;
    logic [67:0] h;
    n = exp_q.size();
    h = (n != 0) ? exp_q[0] : '0;
    check_eq({tag, ".count"},    32'(Count),     32'(n));
    check_eq({tag, ".memvalid"}, 32'(MemValid),  32'(n != 0));
    check_eq({tag, ".memaddr"},  MemAddr,        h[67:36]);
    check_eq({tag, ".memdata"},  MemData,        h[35:4]);
    check_eq({tag, ".membyteen"},32'(MemByteEn), 32'(h[3:0]));
    check_eq({tag, ".reqready"}, 32'(ReqReady),  32'(n != DEPTH));
    check_eq({tag, ".misalign"}, 32'(Misalign),  32'(exp_misalign));
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks at the next falling edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, input logic mr, input string tag);
    ReqValid = v; StoreSignal = s; Addr = a; In = d; MemReady = mr;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    Rst_n = 1'b0;
    #1;
    check_eq("rst.count",    32'(Count),     32'd0);
    check_eq("rst.memvalid", 32'(MemValid),  32'd0);
    check_eq("rst.reqready", 32'(ReqReady),  32'd1);
    check_eq("rst.misalign", 32'(Misalign),  32'd0);
    check_eq("rst.memaddr",  MemAddr,        32'd0);
    check_eq("rst.memdata",  MemData,        32'd0);
    check_eq("rst.membyteen",32'(MemByteEn), 32'd0);
    exp_q.delete();
    exp_misalign = 1'b0;
    ReqValid = 1'b0; StoreSignal = 2'b00; MemReady = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    check_outputs("rst.post");
  endtask

  initial begin
    Rst_n = 1'b0; ReqValid = 1'b0; StoreSignal = 2'b00; Addr = '0; In = '0; MemReady = 1'b0;
    exp_misalign = 1'b0;
    @(negedge Clk);
    apply_reset();

    // byte store lands in lane 3
    step(1, 2'b10, 32'h1003, 32'h0000_00AB, 0, "sb");
    check_eq("sb.addr", MemAddr, 32'h1000);
    check_eq("sb.data", MemData, 32'hABAB_ABAB);
    check_eq("sb.be",   32'(MemByteEn), 32'h8);
    step(0, 2'b00, 0, 0, 1, "sb.drain");

    // misaligned half and word are rejected with a one-cycle pulse
    step(1, 2'b11, 32'h2001, 32'h1234, 0, "sh.mis");
    check_eq("sh.mis.pulse", 32'(Misalign), 32'd1);
    check_eq("sh.mis.count", 32'(Count),    32'd0);
    step(0, 2'b00, 0, 0, 0, "mis.idle");
    check_eq("mis.idle.pulse", 32'(Misalign), 32'd0);
    step(1, 2'b01, 32'h2002, 32'h5678, 0, "sw.mis");
    check_eq("sw.mis.pulse", 32'(Misalign), 32'd1);
    check_eq("sw.mis.count", 32'(Count),    32'd0);
    step(1, 2'b00, 32'h2001, 0, 0, "none");

    // fill to full, fifth held, then drain in order
    for (int i = 0; i < 5; i++) step(1, 2'b01, 32'h3000 + 32'(4*i), 32'(i + 1), 0, "fill");
    check_eq("full.count", 32'(Count),    32'd4);
    check_eq("full.ready", 32'(ReqReady), 32'd0);
    check_eq("full.head",  MemData,       32'd1);
    step(1, 2'b01, 32'h3010, 32'd5, 1, "firstpop");
    check_eq("firstpop.ready", 32'(ReqReady), 32'd1);
    check_eq("firstpop.head",  MemData,       32'd2);
    for (int i = 0; i < 6; i++) step(0, 2'b00, 0, 0, 1, "drain");
    check_eq("drain.count", 32'(Count), 32'd0);

    // simultaneous accept and pop across pointer wrap
    step(1, 2'b01, 32'h4000, 32'hA0, 0, "pre");
    step(1, 2'b01, 32'h4004, 32'hA1, 0, "pre");
    for (int i = 0; i < 7; i++) step(1, 2'b01, 32'h4008 + 32'(8*i), 32'hB0 + 32'(i), 1, "wrap");
    check_eq("wrap.count", 32'(Count), 32'd2);
    check_eq("wrap.head",  MemData,    32'hB5);

    // reset discards held entries
    step(0, 2'b00, 0, 0, 0, "hold");
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 1, "postrst");

    // merge scenario
    step(1, 2'b01, 32'h10, 32'h1122_3344, 0, "m0");
    step(1, 2'b10, 32'h20, 32'hAA, 0, "m1");
    step(1, 2'b10, 32'h21, 32'hBB, 0, "m2");
`ifdef STORE_BUFFER_MERGE_EN
    check_eq("merge.count", 32'(Count), 32'd2);
`else
    check_eq("merge.count", 32'(Count), 32'd3);
`endif
    step(0, 2'b00, 0, 0, 1, "m.pop");
`ifdef STORE_BUFFER_MERGE_EN
    check_eq("merge.data", 32'(MemData[15:0]), 32'h0000_BBAA);
    check_eq("merge.be",   32'(MemByteEn),     32'h3);
`else
    check_eq("merge.data", 32'(MemData[15:0]), 32'h0000_AAAA);
    check_eq("merge.be",   32'(MemByteEn),     32'h1);
`endif
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 1, "m.drain");

    // randomized traffic over a small address window so merges and misaligns are frequent
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, $urandom,
           $urandom_range(0, 2) == 0, "rnd");
      if ($urandom_range(0, 249) == 0) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
